// File: rtl/lock_access_controller.sv
// lock_access_controller
//   Downstream policy stage for the 01011 sequence-detector lock, clocked on the
//   divided 5 Hz tick. It takes the detector's one-cycle unlock pulse and the OR'd
//   key strobes. From these it runs a timed door-open window and counts failed
//   attempts. After too many failures it enters a timed lockout with an alarm.
//   It gates key entry back to the detector and drives a status code for the
//   seven-segment decoder.
//
// Ports
//   clk_5hz       in   divided system tick, rising-edge active
//   reset         in   asynchronous, active-high reset
//   unlock_pulse  in   one-cycle pulse when the detector matches the code
//   key_pulse     in   one-cycle pulse per accepted key press
//   door_open     out  high while the door is released
//   alarm         out  lockout alarm indicator
//   key_gate      out  high when key entry is permitted
//   fail_cnt      out  consecutive failed-attempt count
//   state_code    out  0 = LOCKED, 1 = OPEN, 2 = LOCKOUT
//
// Build option
//   LOCK_ALARM_BLINK_EN : when defined, alarm blinks (1,0,1,0,...) during
//   lockout instead of holding steady at 1. State timing is unchanged.
module lock_access_controller #(
  parameter int CODE_LEN      = 5,
  parameter int MAX_FAIL      = 3,
  parameter int OPEN_TICKS    = 25,
  parameter int LOCKOUT_TICKS = 50
) (
  input  logic                            clk_5hz,
  input  logic                            reset,
  input  logic                            unlock_pulse,
  input  logic                            key_pulse,
  output logic                            door_open,
  output logic                            alarm,
  output logic                            key_gate,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic [2:0]                      state_code
);

  localparam int MAX_TICKS = (OPEN_TICKS > LOCKOUT_TICKS) ? OPEN_TICKS : LOCKOUT_TICKS;
  localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int KEY_W     = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FAIL_W    = $clog2(MAX_FAIL+1);

  localparam logic [KEY_W-1:0]   KEY_LAST   = KEY_W'(CODE_LEN-1);
  localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAIL-1);
  localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(OPEN_TICKS-1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCKOUT_TICKS-1);

  // Encoding doubles as the seven-segment status code.
  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t              state_q,      state_d;
  logic [KEY_W-1:0]    key_cnt_q,    key_cnt_d;
  logic [FAIL_W-1:0]   fail_cnt_q,   fail_cnt_d;
  logic [TIMER_W-1:0]  timer_q,      timer_d;
  logic                door_open_q,  door_open_d;
  logic                alarm_q,      alarm_d;
  logic                key_gate_q,   key_gate_d;
  logic [2:0]          state_code_q, state_code_d;

  always_ff @(posedge clk_5hz or posedge reset) begin
    if (reset) begin
      state_q      <= LOCKED;
      key_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      timer_q      <= '0;
      door_open_q  <= 1'b0;
      alarm_q      <= 1'b0;
      key_gate_q   <= 1'b1;
      state_code_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      key_cnt_q    <= key_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      door_open_q  <= door_open_d;
      alarm_q      <= alarm_d;
      key_gate_q   <= key_gate_d;
      state_code_q <= state_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_cnt_d  = key_cnt_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;

    case (state_q)
      LOCKED: begin
        // The detector's Mealy output lands on the final key strobe, so an
        // unlock must take priority over counting that key as a failure.
        if (unlock_pulse) begin
          state_d    = OPEN;
          timer_d    = OPEN_LOAD;
          key_cnt_d  = '0;
          fail_cnt_d = '0;
        end else if (key_pulse) begin
          if (key_cnt_q == KEY_LAST) begin
            key_cnt_d = '0;
            if (fail_cnt_q == FAIL_LAST) begin
              state_d    = LOCKOUT;
              timer_d    = LOCK_LOAD;
              fail_cnt_d = '0;
            end else begin
              fail_cnt_d = fail_cnt_q + 1'b1;
            end
          end else begin
            key_cnt_d = key_cnt_q + 1'b1;
          end
        end
      end

      OPEN, LOCKOUT: begin
        // Inputs are ignored while timing out; loading TICKS-1 and leaving on
        // zero gives exactly TICKS cycles in the state.
        if (timer_q == '0) begin
          state_d   = LOCKED;
          key_cnt_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d    = LOCKED;
        key_cnt_d  = '0;
        fail_cnt_d = '0;
        timer_d    = '0;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they track it with
  // the same one-edge latency as the state itself.
  always_comb begin
    door_open_d  = (state_d == OPEN);
    key_gate_d   = (state_d == LOCKED);
    state_code_d = {1'b0, state_d};
`ifdef LOCK_ALARM_BLINK_EN
    // High on lockout entry, then toggles every tick; cleared on exit.
    alarm_d      = (state_d == LOCKOUT) && ((state_q != LOCKOUT) || !alarm_q);
`else
    alarm_d      = (state_d == LOCKOUT);
`endif
  end

  assign door_open  = door_open_q;
  assign alarm      = alarm_q;
  assign key_gate   = key_gate_q;
  assign fail_cnt   = fail_cnt_q;
  assign state_code = state_code_q;

endmodule
